// File: rtl/day_of_week_controller.sv
// Day-of-week sequencer: advances on midnight ticks in RUN, lets the user step the
// day in SET while the display blinks. day_code 15 blanks the day decoder.
module day_of_week_controller #(
   parameter int BLINK_HALF = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       day_tick,
   input  logic       set_btn,
   input  logic       inc_btn,
   output logic [3:0] day_code,
   output logic       week_tick,
   output logic       setting
);

   localparam int CW = $clog2(BLINK_HALF);
   localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_HALF - 1);
   localparam logic [3:0] CODE_BLANK = 4'd15;

   typedef enum logic {RUN, SET} mode_t;

   mode_t         mode_reg, mode_next;
   logic [2:0]    day_reg, day_next;
   logic [CW-1:0] blink_cnt_reg, blink_cnt_next;
   logic          blink_on_reg, blink_on_next;
   logic          set_prev_reg, inc_prev_reg;
   logic [3:0]    day_code_reg, day_code_next;
   logic          week_tick_reg, week_tick_next;
   logic          setting_reg, setting_next;
   logic          set_edge, inc_edge;

   // A stray 7 also folds back to 0 on the next advance.
   function automatic logic [2:0] advance(input logic [2:0] d);
      return (d >= 3'd6) ? 3'd0 : d + 3'd1;
   endfunction

   assign set_edge = set_btn & ~set_prev_reg;
   assign inc_edge = inc_btn & ~inc_prev_reg;

   always_comb begin
      mode_next      = mode_reg;
      day_next       = day_reg;
      blink_cnt_next = blink_cnt_reg;
      blink_on_next  = blink_on_reg;
      week_tick_next = 1'b0;
      case (mode_reg)
         RUN: begin
            blink_cnt_next = '0;
            blink_on_next  = 1'b1;
            if (day_tick) begin
               day_next       = advance(day_reg);
               week_tick_next = (day_reg == 3'd6);
            end
            if (set_edge)
               mode_next = SET;
         end
         default: begin
            // Leaving SET takes priority over a simultaneous increment.
            if (set_edge) begin
               mode_next      = RUN;
               blink_cnt_next = '0;
               blink_on_next  = 1'b1;
            end else if (inc_edge) begin
               day_next       = advance(day_reg);
               blink_cnt_next = '0;
               blink_on_next  = 1'b1;
            end else if (blink_cnt_reg == CNT_MAX) begin
               blink_cnt_next = '0;
               blink_on_next  = ~blink_on_reg;
            end else begin
               blink_cnt_next = blink_cnt_reg + CW'(1);
            end
         end
      endcase
      setting_next  = (mode_next == SET);
      day_code_next = (setting_next && !blink_on_next) ? CODE_BLANK : {1'b0, day_next};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_reg      <= RUN;
         day_reg       <= 3'd0;
         blink_cnt_reg <= '0;
         blink_on_reg  <= 1'b1;
         set_prev_reg  <= 1'b1;
         inc_prev_reg  <= 1'b1;
         day_code_reg  <= 4'd0;
         week_tick_reg <= 1'b0;
         setting_reg   <= 1'b0;
      end else begin
         mode_reg      <= mode_next;
         day_reg       <= day_next;
         blink_cnt_reg <= blink_cnt_next;
         blink_on_reg  <= blink_on_next;
         set_prev_reg  <= set_btn;
         inc_prev_reg  <= inc_btn;
         day_code_reg  <= day_code_next;
         week_tick_reg <= week_tick_next;
         setting_reg   <= setting_next;
      end
   end

   assign day_code  = day_code_reg;
   assign week_tick = week_tick_reg;
   assign setting   = setting_reg;

endmodule
